// File: rtl/ram_port_sequencer.sv
// Request/response front-end for a single-port no-change RAM: issues requests to the RAM
// pins, tracks reads through the RAM latency and returns data through a credit-protected FIFO.
module ram_port_sequencer #(
  parameter int    RAM_WIDTH       = 8,
  parameter int    RAM_DEPTH       = 256,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int    RSP_DEPTH       = 4,
  localparam int   ADDR_W          = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_data,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic                 ram_regcea,
  output logic                 ram_rsta,
  input  logic [RAM_WIDTH-1:0] ram_douta
);

  localparam int LAT   = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  logic [LAT:0]           rd_pipe;
  logic [RAM_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]       count, credit;
  logic [RAM_WIDTH-1:0]   head_nxt;
  logic                   accept, rd_accept, push, pop;

  // Credit covers every read from acceptance until its response is popped,
  // so the FIFO can always absorb whatever is still in the RAM pipeline.
  assign req_ready = !rsta && (credit < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign push      = rd_pipe[LAT];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign ram_rsta   = rsta;
  assign ram_regcea = (LAT == 2) ? rd_pipe[1] : 1'b0;

  always_ff @(posedge clka) begin
    if (rsta) begin
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else begin
      ram_ena <= accept;
      ram_wea <= accept && req_we;
      if (accept) begin
        ram_addra <= req_addr;
        ram_dina  <= req_wdata;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) rd_pipe <= '0;
    else      rd_pipe <= {rd_pipe[LAT-1:0], rd_accept};
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      credit <= '0;
    end else begin
      case ({rd_accept, pop})
        2'b10:   credit <= credit + CNT_W'(1);
        2'b01:   credit <= credit - CNT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    if (pop)  rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
  end

  // The registered head follows the entry that will sit at the read pointer next
  // cycle; an incoming word only becomes the head when the FIFO is about to be empty.
  always_comb begin
    head_nxt = rsp_data;
    if (push && ((count == '0) || (pop && count == CNT_W'(1))))
      head_nxt = ram_douta;
    else if (pop && (count > CNT_W'(1)))
      head_nxt = fifo_mem[rd_ptr_nxt];
  end

  always_ff @(posedge clka) begin
    if (push && !rsta) fifo_mem[wr_ptr] <= ram_douta;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rsp_data <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rsp_data <= head_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_credit_bound: assert property (@(posedge clka) disable iff (rsta)
    credit <= DEPTH_C);
  a_no_push_full: assert property (@(posedge clka) disable iff (rsta)
    !(push && count == DEPTH_C));
  a_rsp_stable: assert property (@(posedge clka) disable iff (rsta)
    (rsp_valid && !rsp_ready) |=> $stable(rsp_data));
`endif

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Drives a high-performance and a low-latency sequencer with the same directed stimulus,
// each attached to its own no-change RAM model, and checks them against a request-level model.
module tb_ram_port_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rsta, req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  // index 0 = HIGH_PERFORMANCE (latency 2), index 1 = LOW_LATENCY (latency 1)
  logic          req_ready_w  [2];
  logic          rsp_valid_w  [2];
  logic [DW-1:0] rsp_data_w   [2];
  logic          ram_ena_w    [2];
  logic          ram_wea_w    [2];
  logic [AW-1:0] ram_addra_w  [2];
  logic [DW-1:0] ram_dina_w   [2];
  logic          ram_regcea_w [2];
  logic          ram_rsta_w   [2];
  logic [DW-1:0] ram_douta_w  [2];

  int total, bad;
  int acc_cnt [2];
  int pop_cnt [2];
  logic [DW-1:0] pop_log [2][64];

  ram_port_sequencer #(.RAM_WIDTH(DW), .RAM_DEPTH(256),
                       .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .RSP_DEPTH(DEPTH)) u_hp (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[0]),
    .ram_ena(ram_ena_w[0]), .ram_wea(ram_wea_w[0]), .ram_addra(ram_addra_w[0]),
    .ram_dina(ram_dina_w[0]), .ram_regcea(ram_regcea_w[0]), .ram_rsta(ram_rsta_w[0]),
    .ram_douta(ram_douta_w[0])
  );

  ram_port_sequencer #(.RAM_WIDTH(DW), .RAM_DEPTH(256),
                       .RAM_PERFORMANCE("LOW_LATENCY"), .RSP_DEPTH(DEPTH)) u_ll (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[1]),
    .ram_ena(ram_ena_w[1]), .ram_wea(ram_wea_w[1]), .ram_addra(ram_addra_w[1]),
    .ram_dina(ram_dina_w[1]), .ram_regcea(ram_regcea_w[1]), .ram_rsta(ram_rsta_w[1]),
    .ram_douta(ram_douta_w[1])
  );

  // No-change single-port RAM: a write leaves the read latch untouched.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ram_data;
    logic [DW-1:0] dout_q;
    always @(posedge clka) begin
      if (ram_ena_w[g]) begin
        if (ram_wea_w[g]) mem[ram_addra_w[g]] <= ram_dina_w[g];
        else              ram_data <= mem[ram_addra_w[g]];
      end
      if (ram_rsta_w[g])        dout_q <= '0;
      else if (ram_regcea_w[g]) dout_q <= ram_data;
    end
    assign ram_douta_w[g] = (g == 1) ? ram_data : dout_q;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic string tag(input int i);
    return (i == 0) ? "hp" : "ll";
  endfunction

  // Request-level model: every accepted read becomes a response entry that turns
  // visible LAT+2 cycles after acceptance; credit is simply accepted-minus-popped.
  logic [DW-1:0] m_mem  [2][256];
  logic [DW-1:0] m_data [2][512];
  int            m_due  [2][512];
  int            m_tail [2];
  int            m_head [2];
  logic          m_ena [2], m_wea [2], m_rd1 [2], m_rd2 [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_din  [2];
  int            mcyc;
  bit            model_on;

  always @(negedge clka) begin
    for (int i = 0; i < 2; i++) begin
      int   lat;
      logic exp_ready, exp_valid;
      lat       = (i == 0) ? 2 : 1;
      exp_ready = !rsta && ((m_tail[i] - m_head[i]) < DEPTH);
      exp_valid = (m_head[i] < m_tail[i]) && (m_due[i][m_head[i]] <= mcyc);
      if (model_on) begin
        checkOutput({tag(i), "_req_ready"},  32'(req_ready_w[i]),  32'(exp_ready));
        checkOutput({tag(i), "_rsp_valid"},  32'(rsp_valid_w[i]),  32'(exp_valid));
        if (exp_valid)
          checkOutput({tag(i), "_rsp_data"}, 32'(rsp_data_w[i]), 32'(m_data[i][m_head[i]]));
        checkOutput({tag(i), "_ram_ena"},    32'(ram_ena_w[i]),    32'(m_ena[i]));
        checkOutput({tag(i), "_ram_wea"},    32'(ram_wea_w[i]),    32'(m_wea[i]));
        checkOutput({tag(i), "_ram_addra"},  32'(ram_addra_w[i]),  32'(m_addr[i]));
        checkOutput({tag(i), "_ram_dina"},   32'(ram_dina_w[i]),   32'(m_din[i]));
        checkOutput({tag(i), "_ram_regcea"}, 32'(ram_regcea_w[i]), 32'((i == 0) ? m_rd2[i] : 1'b0));
        checkOutput({tag(i), "_ram_rsta"},   32'(ram_rsta_w[i]),   32'(rsta));
      end
      if (rsta) begin
        m_head[i] = m_tail[i];
        m_ena[i]  = 1'b0;
        m_wea[i]  = 1'b0;
        m_addr[i] = '0;
        m_din[i]  = '0;
        m_rd1[i]  = 1'b0;
        m_rd2[i]  = 1'b0;
      end else begin
        if (exp_valid && rsp_ready) m_head[i]++;
        m_rd2[i] = m_rd1[i];
        m_rd1[i] = 1'b0;
        if (req_valid && exp_ready) begin
          m_ena[i]  = 1'b1;
          m_wea[i]  = req_we;
          m_addr[i] = req_addr;
          m_din[i]  = req_wdata;
          if (req_we) begin
            m_mem[i][req_addr] = req_wdata;
          end else begin
            m_data[i][m_tail[i]] = m_mem[i][req_addr];
            m_due[i][m_tail[i]]  = mcyc + lat + 2;
            m_tail[i]++;
            m_rd1[i] = 1'b1;
          end
        end else begin
          m_ena[i] = 1'b0;
          m_wea[i] = 1'b0;
        end
      end
    end
    if (rsta) model_on = 1'b1;
    mcyc++;
  end

  // Drives one cycle of request inputs and logs accepts/pops seen in that cycle.
  task automatic applyStimulus(input logic v, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clka);
    for (int i = 0; i < 2; i++) begin
      if (v && req_ready_w[i]) acc_cnt[i]++;
      if (rsp_valid_w[i] && rsp_ready) begin
        if (pop_cnt[i] < 64) pop_log[i][pop_cnt[i]] = rsp_data_w[i];
        pop_cnt[i]++;
      end
    end
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  int acc0 [2];
  int pop0 [2];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0;
      pop_cnt[i] = 0;
    end
    rsta      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    @(posedge clka);
    #1;

    $display("[TB] reset state");
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_rst_req_ready"}, 32'(req_ready_w[i]), 32'd0);
      checkOutput({tag(i), "_rst_rsp_valid"}, 32'(rsp_valid_w[i]), 32'd0);
      checkOutput({tag(i), "_rst_rsp_data"},  32'(rsp_data_w[i]),  32'd0);
      checkOutput({tag(i), "_rst_ram_ena"},   32'(ram_ena_w[i]),   32'd0);
      checkOutput({tag(i), "_rst_ram_addra"}, 32'(ram_addra_w[i]), 32'd0);
      checkOutput({tag(i), "_rst_ram_rsta"},  32'(ram_rsta_w[i]),  32'd1);
    end
    idle(1);
    rsta = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      checkOutput({tag(i), "_ready_after_rst"}, 32'(req_ready_w[i]), 32'd1);

    $display("[TB] write then read latency");
    applyStimulus(1'b1, 1'b1, 8'h10, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
    idle(1);
    checkOutput("ll_valid_t2", 32'(rsp_valid_w[1]), 32'd0);
    idle(1);
    checkOutput("ll_valid_t3", 32'(rsp_valid_w[1]), 32'd1);
    checkOutput("ll_data_t3",  32'(rsp_data_w[1]),  32'hA5);
    checkOutput("hp_valid_t3", 32'(rsp_valid_w[0]), 32'd0);
    idle(1);
    checkOutput("hp_valid_t4", 32'(rsp_valid_w[0]), 32'd1);
    checkOutput("hp_data_t4",  32'(rsp_data_w[0]),  32'hA5);
    checkOutput("ll_data_t4",  32'(rsp_data_w[1]),  32'hA5);
    rsp_ready = 1'b1;
    idle(1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      checkOutput({tag(i), "_drained_t5"}, 32'(rsp_valid_w[i]), 32'd0);

    $display("[TB] streaming reads");
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, AW'(k), DW'(k * 3 + 1));
    rsp_ready = 1'b1;
    pop0[1] = pop_cnt[1];
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("ll_stream_ready_%0d", k), 32'(req_ready_w[1]), 32'd1);
      applyStimulus(1'b1, 1'b0, AW'(k), '0);
    end
    idle(8);
    checkOutput("ll_stream_count", 32'(pop_cnt[1] - pop0[1]), 32'd16);
    checkOutput("ll_stream_first", 32'(pop_log[1][pop0[1]]),      32'd1);
    checkOutput("ll_stream_mid",   32'(pop_log[1][pop0[1] + 7]),  32'd22);
    checkOutput("ll_stream_last",  32'(pop_log[1][pop0[1] + 15]), 32'd46);

    $display("[TB] backpressure fills credit");
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) acc0[i] = acc_cnt[i];
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, AW'(k), '0);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_bp_accepts"}, 32'(acc_cnt[i] - acc0[i]), 32'd4);
      checkOutput({tag(i), "_bp_ready"},   32'(req_ready_w[i]),        32'd0);
      pop0[i] = pop_cnt[i];
    end
    rsp_ready = 1'b1;
    idle(6);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_bp_pops"}, 32'(pop_cnt[i] - pop0[i]), 32'd4);
      checkOutput({tag(i), "_bp_data3"}, 32'(pop_log[i][pop0[i] + 3]), 32'd10);
      acc0[i] = acc_cnt[i];
    end
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h06, '0);
    applyStimulus(1'b1, 1'b0, 8'h07, '0);
    for (int i = 0; i < 2; i++)
      checkOutput({tag(i), "_bp_more_accepts"}, 32'(acc_cnt[i] - acc0[i]), 32'd2);
    rsp_ready = 1'b1;
    idle(8);

    $display("[TB] write/read ordering");
    for (int i = 0; i < 2; i++) pop0[i] = pop_cnt[i];
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h20, '0);
    applyStimulus(1'b1, 1'b0, 8'h20, '0);
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h20, '0);
    idle(8);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_wr_rd_new"},    32'(pop_log[i][pop0[i]]),     32'h3C);
      checkOutput({tag(i), "_inflight_old"}, 32'(pop_log[i][pop0[i] + 1]), 32'h3C);
      checkOutput({tag(i), "_after_write"},  32'(pop_log[i][pop0[i] + 2]), 32'h77);
    end

    $display("[TB] reset with reads pending");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h01, '0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 8'h02, '0);
    applyStimulus(1'b1, 1'b0, 8'h03, '0);
    rsta = 1'b1;
    idle(1);
    rsta = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_mid_rst_data"}, 32'(rsp_data_w[i]), 32'd0);
      pop0[i] = pop_cnt[i];
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("%s_post_rst_valid_%0d", tag(i), k), 32'(rsp_valid_w[i]), 32'd0);
        checkOutput($sformatf("%s_post_rst_ena_%0d", tag(i), k),   32'(ram_ena_w[i]),   32'd0);
      end
      idle(1);
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_post_rst_pops"}, 32'(pop_cnt[i] - pop0[i]), 32'd0);
      acc0[i] = acc_cnt[i];
    end
    for (int k = 4; k < 8; k++) applyStimulus(1'b1, 1'b0, AW'(k), '0);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag(i), "_post_rst_accepts"}, 32'(acc_cnt[i] - acc0[i]), 32'd4);
      checkOutput({tag(i), "_post_rst_full"},    32'(req_ready_w[i]),        32'd0);
    end
    rsp_ready = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
